data_sram_axi_bridge: RTL
=========================

Name: data_sram_axi_bridge

Overview:
- Responder for the memory stage's SRAM-style data port (mem_en / mem_wen / mem_addr / mem_wdata / mem_rdata).
- Converts each enabled access into a single-beat AXI4 read or write transaction on the data master port.
- Stalls the pipeline until the access completes, then presents a registered read result.
- Sits between the memory stage and the system AXI interconnect, on the data side only.

Parameters:
ID_WIDTH, 4, width of the AXI ID fields.
AXI_ID, 1, constant ID driven on arid/awid; the data side is distinct from the instruction side.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-low.
mem_en  input  1  access request; held stable by the pipeline while mem_stall=1.
mem_wen  input  4  byte write enables; 0 means read.
mem_addr  input  32  byte address.
mem_wdata  input  32  write data, already lane-replicated.
mem_rdata  output  32  registered read word, full 32-bit lane.
mem_stall  output  1  freeze the pipeline.
bus_error  output  1  one-cycle pulse: the completed access returned a non-OKAY response.
arid/araddr/arlen/arsize/arburst/arvalid  output  ID_WIDTH/32/8/3/2/1  AXI read address channel.
arready  input  1
rdata/rresp/rlast/rvalid  input  32/2/1/1
rready  output  1
awid/awaddr/awlen/awsize/awburst/awvalid  output  ID_WIDTH/32/8/3/2/1  AXI write address channel.
awready  input  1
wdata/wstrb/wlast/wvalid  output  32/4/1/1
wready  input  1
bresp/bvalid  input  2/1
bready  output  1

Behaviour:
- Reset (rst=0, async): state IDLE. All valid/ready outputs are 0. mem_rdata=0, bus_error=0, aw_done=w_done=0. Request registers are cleared.
- Constant outputs: arlen=awlen=0, arburst=awburst=INCR, wlast=1, arid=awid=AXI_ID.
- mem_stall is combinational:
  - equals mem_en in IDLE;
  - is 1 in RD_ADDR, RD_DATA, WR_REQ and WR_RESP;
  - is 0 in DONE.
- IDLE, mem_en=1: latch addr/wen/wdata.
  - wen==0 goes to RD_ADDR.
  - wen!=0 goes to WR_REQ.
  - mem_en=0 stays in IDLE.
- RD_ADDR: arvalid=1, araddr={addr[31:2],2'b00}, arsize=2. On arready go to RD_DATA.
- RD_DATA: rready=1. On rvalid:
  - mem_rdata<=rdata;
  - err<=(rresp!=OKAY);
  - go to DONE.
- WR_REQ: awvalid and wvalid are raised together; wdata=latched wdata, wstrb=latched wen.
  - Each channel drops its valid after its own handshake, tracked by aw_done / w_done.
  - Handshakes may occur in the same cycle or in either order.
  - When both are done (including same-cycle), clear the flags and go to WR_RESP.
- Write size/address encoding:
  - wen 0001/0010/0100/1000: awsize=0, awaddr=addr.
  - wen 0011/1100: awsize=1, awaddr=addr.
  - Any other wen (1111, 0111, 1110): awsize=2, awaddr={addr[31:2],2'b00}.
- WR_RESP: bready=1. On bvalid: err<=(bresp!=OKAY), go to DONE.
- DONE lasts exactly 1 cycle.
  - mem_stall=0, bus_error=err.
  - The pipeline advances on this edge. The still-asserted mem_en of the same access is ignored, so there is no re-launch.
  - Always go to IDLE next.
- Latency: read = 1 + AR wait + R wait + 1 cycles minimum (4 with zero-wait slave). Write = 4 minimum with zero-wait slave.
- mem_rdata holds its value until the next read completes; writes leave it unchanged.
- Valid signals never drop before their handshake. Address, data and strobe stay stable while valid.
- Reset mid-transaction abandons it immediately. The interconnect shares the reset, so no orphan responses are handled.
- rlast is ignored; exactly one beat is expected.

Decomposition:
- Shared package/common header holds:
  - the bridge_state_t enum (IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE);
  - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR;
  - AXI_BURST_INCR;
  - AXI_SIZE_1/2/4.
- The wen-to-{awsize, address alignment} mapping is a package function.
- No sub-module; the block is a single FSM.

Test Plan:
- Read, zero-wait slave: mem_en=1, wen=0, addr=0x1000_0006.
  - Response: arvalid with araddr=0x1000_0004, arsize=2.
  - rdata=0xDEADBEEF, rresp=0 returns mem_rdata=0xDEADBEEF.
  - mem_stall high 3 cycles then low 1; exactly one AR issued.
- Byte write: wen=0100, addr=0x2002, wdata=0x5A5A5A5A.
  - Response: awaddr=0x2002, awsize=0, wstrb=0100.
  - Exactly one AW and one W; bready seen; stall released after bvalid.
- Channel skew: awready delayed 3 cycles, wready immediate.
  - Response: wvalid drops after 1 handshake, awvalid held stable until awready.
  - No duplicate W beat; WR_RESP entered only after both handshakes.
- Error: read with rresp=SLVERR.
  - Response: bus_error=1 for exactly the DONE cycle, mem_rdata=rdata.
  - Back-to-back write with bresp=OKAY gives bus_error=0.
- Reset mid-op: deassert rst while in RD_DATA with arvalid already handshaken.
  - Response: arvalid/rready/mem_stall/mem_rdata go 0 asynchronously.
  - After release with mem_en=0, the bridge stays IDLE with no bus activity.
- Back-to-back: read then store held by the pipeline.
  - Response: no re-issue during DONE; the second access starts in the IDLE cycle after DONE.
  - 3-byte wen=0111 gives awsize=2, awaddr word-aligned.

Source files
------------

// File: rtl/data_sram_axi_bridge_pkg.sv
// Shared types and AXI encodings for the data-side SRAM-to-AXI bridge.
// Also holds the byte-enable to AXI size/alignment mapping.
package data_sram_axi_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_REQ  = 3'd3,
      WR_RESP = 3'd4,
      DONE    = 3'd5
   } bridge_state_t;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

   localparam logic [2:0] AXI_SIZE_1      = 3'd0;
   localparam logic [2:0] AXI_SIZE_2      = 3'd1;
   localparam logic [2:0] AXI_SIZE_4      = 3'd2;

   typedef struct packed {
      logic [2:0]  size;
      logic [31:0] addr;
   } aw_xlat_t;

   // Single bytes and aligned halfwords keep the byte address; any other
   // strobe pattern is issued as a full word at the word-aligned address.
   function automatic aw_xlat_t wen_to_aw(input logic [3:0]  wen,
                                          input logic [31:0] addr);
      aw_xlat_t x;
      case (wen)
         4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
            x.size = AXI_SIZE_1;
            x.addr = addr;
         end
         4'b0011, 4'b1100: begin
            x.size = AXI_SIZE_2;
            x.addr = addr;
         end
         default: begin
            x.size = AXI_SIZE_4;
            x.addr = {addr[31:2], 2'b00};
         end
      endcase
      return x;
   endfunction

endpackage

// File: rtl/data_sram_axi_bridge.sv
// Memory-stage data port responder: turns each enabled SRAM-style access into
// one single-beat AXI4 read or write and stalls the pipeline until it completes.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for mem_en; request latched on the accepting edge
// RD_ADDR | arvalid up, waiting for arready
// RD_DATA | rready up, waiting for the single read beat
// WR_REQ  | awvalid/wvalid up, each dropped after its own handshake
// WR_RESP | bready up, waiting for the write response
// DONE    | one cycle, stall released, bus_error reports the response
module data_sram_axi_bridge
   import data_sram_axi_bridge_pkg::*;
#(
   parameter int unsigned         ID_WIDTH = 4,
   parameter logic [ID_WIDTH-1:0] AXI_ID   = ID_WIDTH'(1)
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                mem_en,
   input  logic [3:0]          mem_wen,
   input  logic [31:0]         mem_addr,
   input  logic [31:0]         mem_wdata,
   output logic [31:0]         mem_rdata,
   output logic                mem_stall,
   output logic                bus_error,

   output logic [ID_WIDTH-1:0] arid,
   output logic [31:0]         araddr,
   output logic [7:0]          arlen,
   output logic [2:0]          arsize,
   output logic [1:0]          arburst,
   output logic                arvalid,
   input  logic                arready,

   input  logic [31:0]         rdata,
   input  logic [1:0]          rresp,
   input  logic                rlast,
   input  logic                rvalid,
   output logic                rready,

   output logic [ID_WIDTH-1:0] awid,
   output logic [31:0]         awaddr,
   output logic [7:0]          awlen,
   output logic [2:0]          awsize,
   output logic [1:0]          awburst,
   output logic                awvalid,
   input  logic                awready,

   output logic [31:0]         wdata,
   output logic [3:0]          wstrb,
   output logic                wlast,
   output logic                wvalid,
   input  logic                wready,

   input  logic [1:0]          bresp,
   input  logic                bvalid,
   output logic                bready
);

   bridge_state_t state;
   logic [31:0]   addr_q;
   logic [3:0]    wen_q;
   logic [31:0]   wdata_q;
   logic          aw_done;
   logic          w_done;
   logic          err_q;
   logic          aw_all;
   logic          w_all;
   aw_xlat_t      aw_xlat;

   // Exactly one beat is expected, so the last flag carries no information.
   logic          unused_rlast;
   assign unused_rlast = rlast;

   assign arid    = AXI_ID;
   assign arlen   = 8'd0;
   assign arburst = AXI_BURST_INCR;
   assign arsize  = AXI_SIZE_4;
   assign araddr  = {addr_q[31:2], 2'b00};
   assign arvalid = (state == RD_ADDR);
   assign rready  = (state == RD_DATA);

   assign aw_xlat = wen_to_aw(wen_q, addr_q);
   assign awid    = AXI_ID;
   assign awlen   = 8'd0;
   assign awburst = AXI_BURST_INCR;
   assign awsize  = aw_xlat.size;
   assign awaddr  = aw_xlat.addr;
   assign awvalid = (state == WR_REQ) && !aw_done;

   assign wdata   = wdata_q;
   assign wstrb   = wen_q;
   assign wlast   = 1'b1;
   assign wvalid  = (state == WR_REQ) && !w_done;
   assign bready  = (state == WR_RESP);

   // Handshake either earlier or on this edge counts as done.
   assign aw_all  = aw_done || (awvalid && awready);
   assign w_all   = w_done  || (wvalid  && wready);

   assign bus_error = (state == DONE) && err_q;

   always_comb begin
      mem_stall = 1'b1;
      case (state)
         IDLE:    mem_stall = mem_en;
         DONE:    mem_stall = 1'b0;
         default: mem_stall = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         addr_q    <= '0;
         wen_q     <= '0;
         wdata_q   <= '0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         err_q     <= 1'b0;
         mem_rdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_en) begin
                  addr_q  <= mem_addr;
                  wen_q   <= mem_wen;
                  wdata_q <= mem_wdata;
                  state   <= (mem_wen == 4'b0000) ? RD_ADDR : WR_REQ;
               end
            end
            RD_ADDR: begin
               if (arready) state <= RD_DATA;
            end
            RD_DATA: begin
               if (rvalid) begin
                  mem_rdata <= rdata;
                  err_q     <= (rresp != AXI_RESP_OKAY);
                  state     <= DONE;
               end
            end
            WR_REQ: begin
               if (aw_all && w_all) begin
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
                  state   <= WR_RESP;
               end else begin
                  aw_done <= aw_all;
                  w_done  <= w_all;
               end
            end
            WR_RESP: begin
               if (bvalid) begin
                  err_q <= (bresp != AXI_RESP_OKAY);
                  state <= DONE;
               end
            end
            // The pipeline still shows this access's mem_en here; never relaunch.
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
